// File: rtl/hex_7seg_scan_if.sv
// Display-side bundle for hex_7seg_scan: the control and value inputs
// coming from core logic plus the registered pin drive going to the board.
// The master modport belongs to whoever supplies the value; the slave
// modport belongs to the scan driver.
interface hex_7seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    display_on;
  logic                    update;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    lz_blank;
  logic [6:0]              seg;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    frame_done;

  modport master (
    output display_on, update, value, dp, lz_blank,
    input  seg, dp_n, an_n, frame_done
  );

  modport slave (
    input  display_on, update, value, dp, lz_blank,
    output seg, dp_n, an_n, frame_done
  );
endinterface

// File: rtl/hex_7seg_scan.sv
// Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits.
// One digit is lit per REFRESH_DIV-cycle period, with all anodes dark for
// the first BLANK_CYCLES of each period to stop ghosting. New values are
// staged and only committed at the end of a full scan so a frame never
// shows a mix of old and new digits. All pin outputs are registered.
module hex_7seg_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input logic             clk,
  input logic             rst_n,
  hex_7seg_scan_if.slave  bus
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] LAST_P   = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_P  = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]    SEG_OFF  = 7'h7F;

  logic [PW-1:0]           p;
  logic [IW-1:0]           idx;
  logic                    last_p;
  logic                    boundary;

  logic [4*NUM_DIGITS-1:0] stage_val;
  logic [NUM_DIGITS-1:0]   stage_dp;
  logic [4*NUM_DIGITS-1:0] disp_val;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic                    pending;

  logic [NUM_DIGITS-1:0]   blank_vec;
  logic                    run_zero;
  logic [3:0]              nibble;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic [6:0]              seg_nxt;

  logic [6:0]              seg_q;
  logic                    dp_n_q;
  logic [NUM_DIGITS-1:0]   an_n_q;
  logic                    frame_done_q;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h18;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      4'hF: decode = 7'h0E;
    endcase
  endfunction

  assign last_p   = (p == LAST_P);
  assign boundary = last_p && (idx == LAST_IDX);

  // Prescaler and digit index; idx steps once per digit period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p   <= '0;
      idx <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the
      // pre-edge values of its neighbours, so ordering inside the block
      // never changes behaviour.
      if (last_p) begin
        p   <= '0;
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end else begin
        p <= p + 1'b1;
      end
    end
  end

  // Staging/display double buffer; commit only at the frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these are a handful of flops rather than a RAM, so they take
      // the reset and a fresh power-up always shows zeros.
      stage_val <= '0;
      stage_dp  <= '0;
      disp_val  <= '0;
      disp_dp   <= '0;
      pending   <= 1'b0;
    end else begin
      if (boundary && pending) begin
        disp_val <= stage_val;
        disp_dp  <= stage_dp;
      end
      // A strobe in the boundary cycle lands in staging and stays pending
      // for the next frame; otherwise the boundary clears the flag.
      if (bus.update) begin
        stage_val <= bus.value;
        stage_dp  <= bus.dp;
        pending   <= 1'b1;
      end else if (boundary) begin
        pending <= 1'b0;
      end
    end
  end

  // Leading-zero mask, current nibble decode and one-cold anode select.
  always_comb begin
    // NOTE: every variable gets a default before any conditional or loop
    // writes it, so no path leaves a value held and no latch is inferred.
    run_zero  = 1'b1;
    blank_vec = '0;
    an_sel    = '1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      run_zero     = run_zero && (disp_val[4*i +: 4] == 4'h0);
      blank_vec[i] = run_zero;
    end
    nibble      = disp_val[{idx, 2'b00} +: 4];
    an_sel[idx] = 1'b0;
    seg_nxt     = (bus.lz_blank && blank_vec[idx]) ? SEG_OFF : decode(nibble);
  end

  // Registered pin drive; display_on only masks the pins, never the scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q        <= SEG_OFF;
      dp_n_q       <= 1'b1;
      an_n_q       <= '1;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= boundary;
      if (!bus.display_on) begin
        seg_q  <= SEG_OFF;
        dp_n_q <= 1'b1;
        an_n_q <= '1;
      end else begin
        seg_q  <= seg_nxt;
        dp_n_q <= ~disp_dp[idx];
        an_n_q <= (p < BLANK_P) ? '1 : an_sel;
      end
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.an_n       = an_n_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_7seg_scan.sv
// Directed bench for hex_7seg_scan with 4 digits, 8-cycle digit periods and
// 2 blanking cycles (32-cycle frames). Every cycle of each frame is compared
// as one packed word {frame_done, an_n, dp_n, seg} against the expected
// digit patterns for that frame.
module tb_hex_7seg_scan;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FRAME = ND * RD;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  hex_7seg_scan_if #(.NUM_DIGITS(ND)) bus ();

  hex_7seg_scan #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected digit patterns, packed {digit3, digit2, digit1, digit0}.
  localparam logic [27:0] T_ZERO    = {7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [27:0] T_1234    = {7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [27:0] T_ABCD    = {7'h08, 7'h03, 7'h46, 7'h21};
  localparam logic [27:0] T_0050_LZ = {7'h7F, 7'h7F, 7'h12, 7'h40};
  localparam logic [27:0] T_0050    = {7'h40, 7'h40, 7'h12, 7'h40};
  localparam logic [27:0] T_0000_LZ = {7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [12:0] RESET_WORD = {1'b0, 4'hF, 1'b1, 7'h7F};

  function automatic logic [12:0] observed();
    return {bus.frame_done, bus.an_n, bus.dp_n, bus.seg};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs len cycles of one frame, starting at frame position 0. Position j's
  // inputs are sampled at the edge whose scan state is position j, and the
  // outputs seen right after that edge describe position j.
  task automatic run_frame(input int f, input logic [27:0] tbl, input logic [3:0] edp,
                           input int len, input int upd_at, input logic [15:0] u_val,
                           input logic [3:0] u_dp, input int off_from, input int off_to);
    logic        on;
    logic [6:0]  e_seg;
    logic        e_dpn;
    logic [3:0]  e_an;
    logic        e_fd;
    int          d;
    for (int j = 0; j < len; j++) begin
      bus.update = (j == upd_at);
      if (j == upd_at) begin
        bus.value = u_val;
        bus.dp    = u_dp;
      end
      on = !(j >= off_from && j < off_to);
      bus.display_on = on;
      tick();
      d     = j / RD;
      e_fd  = (j == FRAME - 1);
      e_seg = on ? tbl[7*d +: 7] : 7'h7F;
      e_dpn = on ? ~edp[d] : 1'b1;
      e_an  = (!on || (j % RD) < BC) ? 4'hF : ~(4'b0001 << d);
      check($sformatf("f%0d_j%0d", f, j), observed(), {e_fd, e_an, e_dpn, e_seg});
    end
    bus.update = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n          = 1'b0;
    bus.display_on = 1'b1;
    bus.update     = 1'b0;
    bus.value      = '0;
    bus.dp         = '0;
    bus.lz_blank   = 1'b0;

    // Reset held for 3 cycles.
    repeat (3) tick();
    check("reset_hold", observed(), RESET_WORD);
    rst_n = 1'b1;

    // Frame 0: display still zero; stage 1234 with dp on digit 1.
    run_frame(0, T_ZERO, 4'b0000, FRAME, 5, 16'h1234, 4'b0010, 0, 0);
    // Frame 1: shows 1234; ABCD arrives at cycle 10 and must not tear.
    run_frame(1, T_1234, 4'b0010, FRAME, 10, 16'hABCD, 4'b0000, 0, 0);
    // Frame 2: shows ABCD; an update in the boundary cycle.
    run_frame(2, T_ABCD, 4'b0000, FRAME, FRAME - 1, 16'h1234, 4'b0010, 0, 0);
    // Frame 3: boundary update is still pending, ABCD persists.
    run_frame(3, T_ABCD, 4'b0000, FRAME, -1, 16'h0000, 4'b0000, 0, 0);
    // Frame 4: 1234 commits; display off mid-digit for cycles 12..19.
    run_frame(4, T_1234, 4'b0010, FRAME, 3, 16'h0050, 4'b0000, 12, 20);

    // Frame 5: 0050 with leading-zero blanking; off across the boundary.
    bus.lz_blank = 1'b1;
    run_frame(5, T_0050_LZ, 4'b0000, FRAME, -1, 16'h0000, 4'b0000, 28, FRAME);

    // Frame 6: same value without blanking; stage 0 with dp on digit 3.
    bus.lz_blank = 1'b0;
    run_frame(6, T_0050, 4'b0000, FRAME, 0, 16'h0000, 4'b1000, 0, 0);

    // Frame 7: all-zero value blanked except digit 0; dp on a blanked digit.
    bus.lz_blank = 1'b1;
    run_frame(7, T_0000_LZ, 4'b1000, FRAME, -1, 16'h0000, 4'b0000, 0, 0);

    // Frame 8: partial, with an update left pending, then async reset.
    run_frame(8, T_0000_LZ, 4'b1000, 13, 2, 16'h5555, 4'b1111, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", observed(), RESET_WORD);
    bus.lz_blank = 1'b0;
    tick();
    check("reset_mid_hold", observed(), RESET_WORD);
    rst_n = 1'b1;

    // Frames 9-10: scan restarts from zero and the pending 5555 is lost.
    run_frame(9, T_ZERO, 4'b0000, FRAME, -1, 16'h0000, 4'b0000, 0, 0);
    run_frame(10, T_ZERO, 4'b0000, FRAME, -1, 16'h0000, 4'b0000, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
